// File: rtl/krnl_partialknn_local_sp_streamer.sv
`default_nettype none
// ============================================================================
// Module   : krnl_partialknn_local_sp_streamer
// Purpose  : Read-side sequencer for the partialKnn local scratchpad. It turns
//            fixed-latency URAM reads into a credit-limited valid/ready stream.
// Option   : KNN_SP_STALL_CNT_EN adds the stall_cycles backpressure counter.
// Revision : 1.0 - initial release
// ============================================================================
module krnl_partialknn_local_sp_streamer #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int RdLat        = 2,
  parameter int FifoDepth    = RdLat + 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    start,
  input  logic [AddressWidth-1:0] base_addr,
  input  logic [AddressWidth:0]   count,
  output logic                    busy,
  output logic                    done,
  output logic [AddressWidth-1:0] mem_address0,
  output logic                    mem_ce0,
  output logic                    mem_we0,
  output logic [DataWidth-1:0]    mem_d0,
  input  logic [DataWidth-1:0]    mem_q0,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DataWidth-1:0]    out_data,
  output logic                    out_last
`ifdef KNN_SP_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int c_cnt_w = AddressWidth + 1;
  localparam int c_ptr_w = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int c_occ_w = $clog2(FifoDepth + 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FifoDepth - 1);
  localparam logic [c_occ_w:0]   c_depth    = (c_occ_w + 1)'(FifoDepth);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [AddressWidth-1:0]   r_cursor;
  logic [c_cnt_w-1:0]        r_remaining, r_count, r_ret_cnt;
  logic [RdLat-1:0]          r_vld_sr;
  logic [c_occ_w-1:0]        r_inflight, r_occ;
  logic [c_ptr_w-1:0]        r_wptr, r_rptr;
  logic [DataWidth-1:0]      r_fifo_data [FifoDepth];
  logic                      r_fifo_last [FifoDepth];

  logic             w_start, w_issue, w_ret, w_pop, w_head_last;
  logic [c_occ_w:0] w_credit;

  assign w_start     = (r_state == S_IDLE) && start;
  assign w_credit    = {1'b0, r_inflight} + {1'b0, r_occ};
  assign w_issue     = (r_state == S_RUN) && (r_remaining != '0) && (w_credit < c_depth);
  assign w_ret       = r_vld_sr[RdLat-1];
  assign out_valid   = (r_occ != '0);
  assign w_pop       = out_valid && out_ready;
  assign w_head_last = r_fifo_last[r_rptr];

  assign out_data     = r_fifo_data[r_rptr];
  assign out_last     = out_valid && w_head_last;
  assign mem_address0 = r_cursor;
  assign mem_we0      = 1'b0;
  assign mem_d0       = '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // An empty job passes through DRAIN for one cycle so done lands at T+2.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_ce0     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = (count == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        mem_ce0 = w_issue;
        if (w_issue && (r_remaining == c_cnt_w'(1))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if ((r_count == '0) || (w_pop && w_head_last && (r_inflight == '0)))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cursor    <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_ret_cnt   <= '0;
      r_vld_sr    <= '0;
      r_inflight  <= '0;
      r_occ       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_start) begin
        r_cursor    <= base_addr;
        r_remaining <= count;
        r_count     <= count;
      end else if (w_issue) begin
        r_cursor    <= r_cursor + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      r_vld_sr <= (r_vld_sr << 1) | RdLat'(w_issue);

      unique case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase

      // Last flag follows the ordinal of the returned word, not its address.
      if (w_start) r_ret_cnt <= '0;
      else if (w_ret) r_ret_cnt <= r_ret_cnt + 1'b1;

      if (w_ret) begin
        r_fifo_data[r_wptr] <= mem_q0;
        r_fifo_last[r_wptr] <= ((r_ret_cnt + c_cnt_w'(1)) == r_count);
        r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;

      unique case ({w_ret, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef KNN_SP_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_stall <= '0;
    else if (w_start) r_stall <= '0;
    else if (out_valid && !out_ready && busy && (r_stall != '1)) r_stall <= r_stall + 1'b1;
  end
  assign stall_cycles = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_krnl_partialknn_local_sp_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_krnl_partialknn_local_sp_streamer
// Purpose  : Directed, table-driven bench for the scratchpad read streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_krnl_partialknn_local_sp_streamer;
  localparam int c_dw    = 256;
  localparam int c_aw    = 11;
  localparam int c_rdlat = 2;
  localparam int c_depth = c_rdlat + 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b1;
  logic              start = 1'b0;
  logic [c_aw-1:0]   base_addr = '0;
  logic [c_aw:0]     count = '0;
  logic              busy, done, mem_ce0, mem_we0, out_valid, out_last;
  logic              out_ready = 1'b0;
  logic [c_aw-1:0]   mem_address0;
  logic [c_dw-1:0]   mem_d0, mem_q0, out_data;
`ifdef KNN_SP_STALL_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  krnl_partialknn_local_sp_streamer #(
    .DataWidth(c_dw), .AddressWidth(c_aw), .RdLat(c_rdlat), .FifoDepth(c_depth)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .mem_address0(mem_address0),
    .mem_ce0(mem_ce0), .mem_we0(mem_we0), .mem_d0(mem_d0), .mem_q0(mem_q0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef KNN_SP_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  // Scratchpad model: word i holds i, fixed read latency.
  logic [c_dw-1:0] mem  [2048];
  logic [c_dw-1:0] pipe [c_rdlat];
  always @(posedge ap_clk) begin
    pipe[0] <= mem_ce0 ? mem[mem_address0] : '0;
    for (int k = 1; k < c_rdlat; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_q0 = pipe[c_rdlat-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [c_dw-1:0] act, input logic [c_dw-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"},      c_dw'(busy),         '0);
    check({tag, " done"},      c_dw'(done),         '0);
    check({tag, " mem_ce0"},   c_dw'(mem_ce0),      '0);
    check({tag, " mem_addr"},  c_dw'(mem_address0), '0);
    check({tag, " out_valid"}, c_dw'(out_valid),    '0);
    check({tag, " out_last"},  c_dw'(out_last),     '0);
    check({tag, " out_data"},  out_data,            '0);
  endtask

  typedef struct {
    logic [c_aw-1:0] base;
    logic [c_aw:0]   cnt;
    logic [3:0]      rdy;       // out_ready = rdy[cycle % 4]
    bit              restart;   // extra start pulse while running
    logic [c_dw-1:0] exp_first;
    logic [c_dw-1:0] exp_last;
  } vec_t;

  task automatic run_job(input int id, input vec_t v);
    int cyc = 0, issued = 0, popped = 0, dones = 0, stalls = 0;
    int done_cyc = -1, last_cyc = -1, first_ce = -1, first_vld = -1, max_out = 0;
    int budget = int'(v.cnt) * 8 + 40;
    bit busy1 = 1'b0, prev_hold = 1'b0, prev_last = 1'b0;
    logic [c_dw-1:0] prev_data = '0;
    logic [c_aw-1:0] ea;
    string t = $sformatf("v%0d", id);

    @(posedge ap_clk); #1;
    start = 1'b1; base_addr = v.base; count = v.cnt; out_ready = v.rdy[0];
    while (dones == 0 && cyc < budget) begin
      @(negedge ap_clk);
      if (issued - popped > max_out) max_out = issued - popped;
      if (cyc == 1) busy1 = busy;
      if (mem_ce0) begin
        if (first_ce < 0) first_ce = cyc;
        ea = v.base + c_aw'(issued);
        check({t, " addr"}, c_dw'(mem_address0), c_dw'(ea));
        issued++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (prev_hold) begin
        check({t, " hold valid"}, c_dw'(out_valid), c_dw'(1));
        check({t, " hold data"},  out_data, prev_data);
        check({t, " hold last"},  c_dw'(out_last), c_dw'(prev_last));
      end
      if (out_valid && out_ready) begin
        ea = v.base + c_aw'(popped);
        check({t, " data"}, out_data, c_dw'(ea));
        check({t, " last"}, c_dw'(out_last), c_dw'(popped == int'(v.cnt) - 1));
        if (popped == 0) check({t, " first word"}, out_data, v.exp_first);
        if (popped == int'(v.cnt) - 1) begin
          check({t, " last word"}, out_data, v.exp_last);
          last_cyc = cyc;
        end
        popped++;
      end
      if (out_valid && !out_ready && busy) stalls++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (done) begin
        dones++;
        done_cyc = cyc;
        check({t, " busy at done"}, c_dw'(busy), '0);
      end
      @(posedge ap_clk); #1;
      cyc++;
      start = v.restart && (cyc == 2);
      if (start) begin base_addr = 11'h300; count = 12'd9; end
      out_ready = v.rdy[cyc % 4];
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      if (done) dones++;
      if (mem_ce0) issued++;
      if (out_valid) popped++;
    end
    check({t, " done count"}, c_dw'(dones), c_dw'(1));
    check({t, " words out"},  c_dw'(popped), c_dw'(v.cnt));
    check({t, " reads"},      c_dw'(issued), c_dw'(v.cnt));
    check({t, " credit bound"}, c_dw'(max_out <= c_depth), c_dw'(1));
    check({t, " busy T+1"}, c_dw'(busy1), c_dw'(1));
    if (v.cnt == 0) begin
      check({t, " done T+2"}, c_dw'(done_cyc), c_dw'(2));
    end else begin
      check({t, " done after last"}, c_dw'(done_cyc), c_dw'(last_cyc + 1));
      check({t, " first ce"},  c_dw'(first_ce),  c_dw'(1));
      check({t, " first vld"}, c_dw'(first_vld), c_dw'(c_rdlat + 2));
    end
`ifdef KNN_SP_STALL_CNT_EN
    check({t, " stall_cycles"}, c_dw'(stall_cycles), c_dw'(stalls));
`endif
  endtask

  vec_t vecs [7];

  initial begin
    int popped, cyc;
    bit residue;

    vecs[0] = '{11'h010, 12'd8,    4'b1111, 1'b0, 256'h010, 256'h017};  // basic
    vecs[1] = '{11'h7FE, 12'd4,    4'b1111, 1'b0, 256'h7FE, 256'h001};  // wrap
    vecs[2] = '{11'h000, 12'd16,   4'b1000, 1'b0, 256'h000, 256'h00F};  // backpressure
    vecs[3] = '{11'h055, 12'd0,    4'b1111, 1'b0, 256'h0,   256'h0};    // empty job
    vecs[4] = '{11'h040, 12'd5,    4'b1111, 1'b1, 256'h040, 256'h044};  // start ignored
    vecs[5] = '{11'h123, 12'd2048, 4'b1111, 1'b0, 256'h123, 256'h122};  // full depth
    vecs[6] = '{11'h200, 12'd2,    4'b1111, 1'b0, 256'h200, 256'h201};  // after reset

    for (int i = 0; i < 2048; i++) mem[i] = c_dw'(i);

    #2 ap_rst_n = 1'b0;
    #1 check_reset("por");
    @(posedge ap_clk); @(posedge ap_clk); #1 ap_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(i, vecs[i]);

    // Reset in the middle of a 10-word job.
    @(posedge ap_clk); #1;
    start = 1'b1; base_addr = 11'h100; count = 12'd10; out_ready = 1'b1;
    popped = 0;
    cyc = 0;
    while (popped < 3 && cyc < 40) begin
      @(negedge ap_clk);
      if (out_valid && out_ready) popped++;
      if (popped < 3) begin
        @(posedge ap_clk); #1;
        start = 1'b0;
        cyc++;
      end
    end
    check("midrst words before reset", c_dw'(popped), c_dw'(3));
    #2 ap_rst_n = 1'b0;
    #1 check_reset("midrst");
    start = 1'b0;
    @(posedge ap_clk); #3 ap_rst_n = 1'b1;
    residue = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      if (out_valid || mem_ce0 || busy) residue = 1'b1;
    end
    check("midrst residue", c_dw'(residue), '0);
    run_job(6, vecs[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
